// File: rtl/mem_pkg.sv
// mem_pkg: shared types and default geometry for the memory and its BIST initiator
package mem_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_SIZE = 2048;
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_e;
  typedef enum logic [1:0] {MODE_ADDR_XOR, MODE_CONST, MODE_CHECKER, MODE_INV_ADDR_XOR} mode_e;
endpackage

// File: rtl/mem_pattern_gen.sv
// mem_pattern_gen: combinational expected-data pattern for a given mode, seed and address
module mem_pattern_gen
  import mem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADDR_WIDTH = 8
) (
  input  mode_e                  mode,
  input  logic [WIDTH-1:0]       seed,
  input  logic [ADDR_WIDTH-1:0]  addr,
  output logic [WIDTH-1:0]       pattern
);
  logic [WIDTH-1:0] a_w;
  // address resized to the data width, then combined with the seed per mode
  always_comb begin
    a_w = WIDTH'(addr);
    pattern = mode == MODE_CONST ? seed :
              mode == MODE_CHECKER ? (addr[0] ? ~seed : seed) :
              mode == MODE_INV_ADDR_XOR ? ~(a_w ^ seed) : a_w ^ seed;
  end
endmodule

// File: rtl/mem_bist_initiator.sv
// mem_bist_initiator: write-all / read-all-compare self test over a valid/ready memory port
module mem_bist_initiator
  import mem_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SIZE = DEF_SIZE,
  parameter int DEPTH = SIZE / WIDTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int TIMEOUT = 64,
  parameter int ERR_W = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [1:0]             mode_i,
  input  logic [WIDTH-1:0]       seed_i,
  output logic [ADDR_WIDTH-1:0]  addr_o,
  output logic                   wr_rd_o,
  output logic [WIDTH-1:0]       wdata_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  input  logic [WIDTH-1:0]       rdata_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   pass_o,
  output logic                   timeout_o,
  output logic [ERR_W-1:0]       err_count_o,
  output logic [ADDR_WIDTH-1:0]  first_err_addr_o
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e state_q, state_d;
  mode_e mode_q;
  logic [WIDTH-1:0] seed_q, exp_w;
  logic [ADDR_WIDTH-1:0] addr_q, first_q;
  logic [ERR_W-1:0] err_q;
  logic [CW-1:0] wait_q;
  logic to_q, active, xfer, last, expired, mismatch, launch;

  mem_pattern_gen #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_pat (
    .mode(mode_q),
    .seed(seed_q),
    .addr(addr_q),
    .pattern(exp_w)
  );

  // state register
  always_ff @(posedge clk_i)
    state_q <= rst_i ? IDLE : state_d;

  // next state, handshake qualifiers and port outputs
  always_comb begin
    active = state_q == WRITE || state_q == READ;
    launch = !active && start_i;
    xfer = active && ready_i;
    last = addr_q == ADDR_WIDTH'(DEPTH - 1);
    expired = active && !ready_i && wait_q == CW'(TIMEOUT - 1);
    mismatch = xfer && state_q == READ && rdata_i != exp_w;
    state_d = launch ? WRITE :
              expired ? DONE :
              (xfer && last) ? (state_q == WRITE ? READ : DONE) : state_q;
    valid_o = active;
    busy_o = active;
    wr_rd_o = state_q == WRITE;
    wdata_o = state_q == WRITE ? exp_w : '0;
    addr_o = addr_q;
    done_o = state_q == DONE;
    pass_o = state_q == DONE && err_q == '0 && !to_q;
    timeout_o = to_q;
    err_count_o = err_q;
    first_err_addr_o = first_q;
  end

  // address walk, wait counter and result bookkeeping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= MODE_ADDR_XOR;
      seed_q <= '0;
      addr_q <= '0;
      wait_q <= '0;
      err_q <= '0;
      first_q <= '0;
      to_q <= 1'b0;
    end else if (launch) begin
      mode_q <= mode_e'(mode_i);
      seed_q <= seed_i;
      addr_q <= '0;
      wait_q <= '0;
      err_q <= '0;
      first_q <= '0;
      to_q <= 1'b0;
    end else if (active) begin
      if (xfer) begin
        addr_q <= last ? '0 : addr_q + 1'b1;
        wait_q <= '0;
      end else begin
        wait_q <= wait_q + 1'b1;
        if (expired) to_q <= 1'b1;
      end
      if (mismatch) begin
        if (err_q != '1) err_q <= err_q + 1'b1;
        if (err_q == '0) first_q <= addr_q;
      end
    end
  end
endmodule

// File: tb/tb_mem_bist_initiator.sv
// tb_mem_bist_initiator: directed tests of the memory BIST initiator against a behavioural memory
module tb_mem_bist_initiator;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic start_i = 1'b0;
  logic [1:0] mode_i = 2'd0;
  logic [7:0] seed_i = 8'h00;
  logic [7:0] addr_o, wdata_o, rdata_i, err_count_o, first_err_addr_o;
  logic wr_rd_o, valid_o, ready_i, busy_o, done_o, pass_o, timeout_o;
  logic [7:0] mem [256];
  int rmode = 0;
  bit inj = 1'b0;
  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  mem_bist_initiator #(.WIDTH(8), .SIZE(2048), .TIMEOUT(16), .ERR_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i), .seed_i(seed_i),
    .addr_o(addr_o), .wr_rd_o(wr_rd_o), .wdata_o(wdata_o), .valid_o(valid_o),
    .ready_i(ready_i), .rdata_i(rdata_i), .busy_o(busy_o), .done_o(done_o),
    .pass_o(pass_o), .timeout_o(timeout_o), .err_count_o(err_count_o),
    .first_err_addr_o(first_err_addr_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (valid_o && ready_i && wr_rd_o) mem[addr_o] <= wdata_o;
  end

  assign ready_i = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 4 == 0) : !(wr_rd_o && addr_o >= 8'h07);
  assign rdata_i = (valid_o && !wr_rd_o) ? mem[addr_o] ^ {7'd0, inj && (addr_o == 8'h15 || addr_o == 8'h40)} : 8'h00;

  function automatic logic [7:0] exp_f(input int m, input logic [7:0] s, input int a);
    logic [7:0] av;
    av = a[7:0];
    case (m)
      0: return av ^ s;
      1: return s;
      2: return (a % 2 == 1) ? ~s : s;
      default: return ~(av ^ s);
    endcase
  endfunction

  task automatic pulse_start(input logic [1:0] m, input logic [7:0] s);
    @(negedge clk_i);
    mode_i = m;
    seed_i = s;
    start_i = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic wait_done(input int max, output int c);
    c = 1;
    while (!done_o && c < max) begin
      @(posedge clk_i);
      #1 c++;
    end
    n_checks++;
    if (done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL done_wait: done_o=%b after %0d cycles, required 1", done_o, c);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++;
    if ({valid_o, busy_o, done_o, pass_o, timeout_o, wr_rd_o, addr_o, wdata_o, err_count_o, first_err_addr_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: v=%b b=%b d=%b p=%b t=%b a=%h e=%h required all 0", valid_o, busy_o, done_o, pass_o, timeout_o, addr_o, err_count_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_baseline();
    int c, bad;
    rmode = 0;
    pulse_start(2'd0, 8'hA5);
    n_checks++;
    if ({busy_o, wr_rd_o, addr_o, wdata_o} !== {1'b1, 1'b1, 8'h00, 8'hA5}) begin
      n_fail++;
      $display("FAIL base_first_write: b=%b w=%b a=%h d=%h required 1 1 00 a5", busy_o, wr_rd_o, addr_o, wdata_o);
    end
    wait_done(700, c);
    n_checks++;
    if (c !== 513) begin
      n_fail++;
      $display("FAIL base_latency: got %0d cycles, required 513", c);
    end
    n_checks++;
    if ({pass_o, valid_o, err_count_o, timeout_o} !== {1'b1, 1'b0, 8'h00, 1'b0}) begin
      n_fail++;
      $display("FAIL base_result: p=%b v=%b e=%h t=%b required 1 0 00 0", pass_o, valid_o, err_count_o, timeout_o);
    end
    n_checks++;
    if (mem[8'h15] !== 8'hB0) begin
      n_fail++;
      $display("FAIL base_mem15: got %h, required b0", mem[8'h15]);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_f(0, 8'hA5, i)) bad++;
    n_checks++;
    if (bad !== 0) begin
      n_fail++;
      $display("FAIL base_mem_all: %0d wrong words, required 0", bad);
    end
  endtask

  task automatic test_error_injection();
    int c;
    inj = 1'b1;
    pulse_start(2'd0, 8'hA5);
    wait_done(700, c);
    inj = 1'b0;
    n_checks++;
    if (err_count_o !== 8'd2) begin
      n_fail++;
      $display("FAIL inj_err_count: got %0d, required 2", err_count_o);
    end
    n_checks++;
    if (first_err_addr_o !== 8'h15) begin
      n_fail++;
      $display("FAIL inj_first_addr: got %h, required 15", first_err_addr_o);
    end
    n_checks++;
    if (pass_o !== 1'b0) begin
      n_fail++;
      $display("FAIL inj_pass: got %b, required 0", pass_o);
    end
  endtask

  task automatic test_backpressure();
    int c;
    logic stall;
    logic [7:0] pa, pd;
    rmode = 1;
    pulse_start(2'd2, 8'h3C);
    c = 1;
    stall = 1'b0;
    pa = 8'h00;
    pd = 8'h00;
    while (!done_o && c < 3000) begin
      stall = valid_o && !ready_i;
      pa = addr_o;
      pd = wdata_o;
      @(posedge clk_i);
      #1 c++;
      if (stall) begin
        n_checks++;
        if (addr_o !== pa || wdata_o !== pd) begin
          n_fail++;
          $display("FAIL bp_stable: a=%h d=%h, required a=%h d=%h", addr_o, wdata_o, pa, pd);
        end
      end
    end
    rmode = 0;
    n_checks++;
    if (c < 2040 || c > 2060 || done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d cycles done=%b, required 2040..2060 and done", c, done_o);
    end
    n_checks++;
    if ({mem[0], mem[1], mem[8'h15]} !== {8'h3C, 8'hC3, 8'hC3}) begin
      n_fail++;
      $display("FAIL bp_pattern: got %h %h %h, required 3c c3 c3", mem[0], mem[1], mem[8'h15]);
    end
    n_checks++;
    if (pass_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_pass: got %b, required 1", pass_o);
    end
  endtask

  task automatic test_modes();
    int c;
    pulse_start(2'd3, 8'h0F);
    wait_done(700, c);
    n_checks++;
    if ({mem[8'h21], pass_o} !== {8'hD1, 1'b1}) begin
      n_fail++;
      $display("FAIL mode3: mem21=%h pass=%b, required d1 1", mem[8'h21], pass_o);
    end
    pulse_start(2'd1, 8'h5A);
    wait_done(700, c);
    n_checks++;
    if ({mem[8'h99], mem[8'h00], pass_o} !== {8'h5A, 8'h5A, 1'b1}) begin
      n_fail++;
      $display("FAIL mode1: mem99=%h mem0=%h pass=%b, required 5a 5a 1", mem[8'h99], mem[0], pass_o);
    end
  endtask

  task automatic test_timeout();
    int c;
    rmode = 2;
    pulse_start(2'd0, 8'hA5);
    wait_done(200, c);
    n_checks++;
    if (c !== 24) begin
      n_fail++;
      $display("FAIL to_latency: got %0d cycles, required 24", c);
    end
    n_checks++;
    if ({timeout_o, valid_o, done_o, pass_o} !== 4'b1010) begin
      n_fail++;
      $display("FAIL to_flags: t=%b v=%b d=%b p=%b, required 1 0 1 0", timeout_o, valid_o, done_o, pass_o);
    end
    rmode = 0;
    pulse_start(2'd0, 8'hA5);
    n_checks++;
    if (timeout_o !== 1'b0) begin
      n_fail++;
      $display("FAIL to_clear: got %b, required 0", timeout_o);
    end
    wait_done(700, c);
    n_checks++;
    if (pass_o !== 1'b1) begin
      n_fail++;
      $display("FAIL to_recover_pass: got %b, required 1", pass_o);
    end
  endtask

  task automatic test_control();
    int c, k;
    pulse_start(2'd0, 8'hA5);
    k = 0;
    while (!(busy_o && !wr_rd_o && addr_o == 8'h10) && k < 600) begin
      @(posedge clk_i);
      #1 k++;
    end
    pulse_start(2'd1, 8'h00);
    n_checks++;
    if ({busy_o, wr_rd_o, addr_o} !== {1'b1, 1'b0, 8'h11}) begin
      n_fail++;
      $display("FAIL ctl_ignore_start: b=%b w=%b a=%h, required 1 0 11", busy_o, wr_rd_o, addr_o);
    end
    wait_done(700, c);
    n_checks++;
    if (pass_o !== 1'b1) begin
      n_fail++;
      $display("FAIL ctl_pass_after_ignore: got %b, required 1", pass_o);
    end
    pulse_start(2'd0, 8'hA5);
    k = 0;
    while (!(wr_rd_o && addr_o == 8'h80) && k < 600) begin
      @(posedge clk_i);
      #1 k++;
    end
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    n_checks++;
    if ({valid_o, busy_o, done_o, pass_o, timeout_o, wr_rd_o, addr_o, wdata_o, err_count_o, first_err_addr_o} !== '0) begin
      n_fail++;
      $display("FAIL ctl_mid_reset: v=%b b=%b d=%b a=%h w=%b, required all 0", valid_o, busy_o, done_o, addr_o, wr_rd_o);
    end
    rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if ({valid_o, done_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL ctl_idle_hold: v=%b d=%b, required 0 0", valid_o, done_o);
    end
    pulse_start(2'd0, 8'hA5);
    wait_done(700, c);
    n_checks++;
    if ({pass_o, c} !== {1'b1, 32'd513}) begin
      n_fail++;
      $display("FAIL ctl_fresh_run: pass=%b cycles=%0d, required 1 513", pass_o, c);
    end
  endtask

  initial begin
    test_reset();
    test_baseline();
    test_error_injection();
    test_backpressure();
    test_modes();
    test_timeout();
    test_control();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
